// File: rtl/pmem_arb_pkg.sv
// pmem_arb_pkg: shared types and helpers for the pmem_arbiter slice.
//   arb_state_t      - arbiter FSM states (IDLE, RD, WR, DONE)
//   idx_w()          - index width for n items that never collapses to zero
//   line_offset_bits - number of byte-offset bits inside one cache line
//   align_mask()     - address mask clearing the line byte offset (truncate to ADDR_W)
package pmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } arb_state_t;

    localparam int BYTE_W = 8;

    // $clog2(1) is 0, which would give zero-width counters and pointers.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int line_offset_bits(input int data_w, input int burst_len);
        return $clog2((data_w * burst_len) / BYTE_W);
    endfunction

    function automatic logic [63:0] align_mask(input int off_bits);
        return ~((64'd1 << off_bits) - 64'd1);
    endfunction

endpackage

// File: rtl/pmem_arbiter_rr_grant.sv
// rr_grant: combinational grant picker for pmem_arbiter.
//   req       in  NUM_PORTS  pending request per port
//   rr_ptr    in  PTR_W      first port to consider (round-robin build only)
//   gnt_valid out 1          some port is requesting
//   gnt_idx   out PTR_W      index of the winning port
// Build option PMEM_ARB_FIXED_PRIO_EN: lowest requesting index always wins
// and the rr_ptr port disappears.
module rr_grant
    import pmem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int PTR_W     = idx_w(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
`ifndef PMEM_ARB_FIXED_PRIO_EN
    input  logic [PTR_W-1:0]     rr_ptr,
`endif
    output logic                 gnt_valid,
    output logic [PTR_W-1:0]     gnt_idx
);

    always_comb begin
        int idx;
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
`ifdef PMEM_ARB_FIXED_PRIO_EN
            idx = i;
`else
            // Walk the ports starting at rr_ptr, wrapping at NUM_PORTS.
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
`endif
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: arbitrates NUM_PORTS cache-line clients onto one burst pmem bus.
//   clk, rst        clock (rising edge), synchronous active-low reset
//   cl_read/write   per-client level requests, held until cl_resp
//   cl_address      per-client address, slice i = port i
//   cl_wdata        per-client write line, beat 0 in the low DATA_W bits
//   cl_rdata        shared read line, valid while cl_resp is high
//   cl_resp         one-hot single-cycle completion pulse
//   pmem_*          burst bus: read/write request, line-aligned address,
//                   write beat, read beat, per-beat response
// Build option PMEM_ARB_FIXED_PRIO_EN: fixed lowest-index priority instead
// of round-robin.
module pmem_arbiter
    import pmem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int BURST_LEN = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_PORTS-1:0]                  cl_read,
    input  logic [NUM_PORTS-1:0]                  cl_write,
    input  logic [NUM_PORTS*ADDR_W-1:0]           cl_address,
    input  logic [NUM_PORTS*DATA_W*BURST_LEN-1:0] cl_wdata,
    output logic [DATA_W*BURST_LEN-1:0]           cl_rdata,
    output logic [NUM_PORTS-1:0]                  cl_resp,
    output logic                                  pmem_read,
    output logic                                  pmem_write,
    output logic [ADDR_W-1:0]                     pmem_address,
    output logic [DATA_W-1:0]                     pmem_wdata,
    input  logic [DATA_W-1:0]                     pmem_rdata,
    input  logic                                  pmem_resp
);

    localparam int                LINE_W     = DATA_W * BURST_LEN;
    localparam int                PTR_W      = idx_w(NUM_PORTS);
    localparam int                BEAT_W     = idx_w(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    localparam logic [PTR_W-1:0]  LAST_PORT  = PTR_W'(NUM_PORTS - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(align_mask(line_offset_bits(DATA_W, BURST_LEN)));

    arb_state_t          state;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [BEAT_W-1:0]   beat_nxt;
    logic [PTR_W-1:0]    gnt_idx;
    logic [PTR_W-1:0]    g_q;
    logic                gnt_valid;
    logic                op_write;
    logic [LINE_W-1:0]   wline;
    logic [LINE_W-1:0]   buffer;
    logic [NUM_PORTS-1:0] req;
`ifndef PMEM_ARB_FIXED_PRIO_EN
    logic [PTR_W-1:0]    rr_ptr;
`endif

    assign req      = cl_read | cl_write;
    assign beat_nxt = beat_cnt + 1'b1;

    // The read line is only presented during the completion cycle of a read.
    assign cl_rdata = (state == DONE && !op_write) ? buffer : '0;

    rr_grant #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_grant (
        .req       (req),
`ifndef PMEM_ARB_FIXED_PRIO_EN
        .rr_ptr    (rr_ptr),
`endif
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            g_q          <= '0;
            op_write     <= 1'b0;
            wline        <= '0;
            // NOTE: the line buffer is plain flops, so it can be cleared here; a RAM-mapped buffer could not.
            buffer       <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            cl_resp      <= '0;
`ifndef PMEM_ARB_FIXED_PRIO_EN
            rr_ptr       <= '0;
`endif
        end else begin
            cl_resp <= '0;
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        g_q          <= gnt_idx;
                        op_write     <= cl_write[gnt_idx];
                        pmem_address <= cl_address[gnt_idx*ADDR_W +: ADDR_W] & ALIGN_MASK;
                        wline        <= cl_wdata[gnt_idx*LINE_W +: LINE_W];
                        beat_cnt     <= '0;
                        // Write wins when a client raises both requests.
                        if (cl_write[gnt_idx]) begin
                            state      <= WR;
                            pmem_write <= 1'b1;
                            pmem_wdata <= cl_wdata[gnt_idx*LINE_W +: DATA_W];
                        end else begin
                            state     <= RD;
                            pmem_read <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (pmem_resp) begin
                        buffer[beat_cnt*DATA_W +: DATA_W] <= pmem_rdata;
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt     <= '0;
                            pmem_read    <= 1'b0;
                            cl_resp[g_q] <= 1'b1;
                            state        <= DONE;
                        end else begin
                            beat_cnt <= beat_nxt;
                        end
                    end
                end
                WR: begin
                    if (pmem_resp) begin
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt     <= '0;
                            pmem_write   <= 1'b0;
                            pmem_wdata   <= '0;
                            cl_resp[g_q] <= 1'b1;
                            state        <= DONE;
                        end else begin
                            beat_cnt   <= beat_nxt;
                            pmem_wdata <= wline[beat_nxt*DATA_W +: DATA_W];
                        end
                    end
                end
                DONE: begin
                    // Clients drop their request during this cycle, so IDLE never regrants a finished port.
                    state <= IDLE;
`ifndef PMEM_ARB_FIXED_PRIO_EN
                    rr_ptr <= (g_q == LAST_PORT) ? '0 : g_q + 1'b1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: directed self-checking bench for pmem_arbiter.
// Two instances: the default (2 ports, 4 beats) and a 3-port, 8-beat build.
module tb_pmem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;

    // Default instance: NUM_PORTS=2, DATA_W=64, BURST_LEN=4 (LINE_W=256)
    logic [1:0]   cl_read = '0, cl_write = '0;
    logic [63:0]  cl_address = '0;
    logic [511:0] cl_wdata = '0;
    logic [255:0] cl_rdata;
    logic [1:0]   cl_resp;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [63:0]  pmem_wdata;
    logic [63:0]  pmem_rdata = '0;
    logic         pmem_resp = 1'b0;

    // Wide instance: NUM_PORTS=3, BURST_LEN=8 (LINE_W=512)
    logic [2:0]    cl_read3 = '0, cl_write3 = '0;
    logic [95:0]   cl_address3 = '0;
    logic [1535:0] cl_wdata3 = '0;
    logic [511:0]  cl_rdata3;
    logic [2:0]    cl_resp3;
    logic          pmem_read3, pmem_write3;
    logic [31:0]   pmem_address3;
    logic [63:0]   pmem_wdata3;
    logic [63:0]   pmem_rdata3 = '0;
    logic          pmem_resp3 = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pmem_arbiter u_dut (
        .clk(clk), .rst(rst),
        .cl_read(cl_read), .cl_write(cl_write), .cl_address(cl_address),
        .cl_wdata(cl_wdata), .cl_rdata(cl_rdata), .cl_resp(cl_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    pmem_arbiter #(.NUM_PORTS(3), .BURST_LEN(8)) u_dut3 (
        .clk(clk), .rst(rst),
        .cl_read(cl_read3), .cl_write(cl_write3), .cl_address(cl_address3),
        .cl_wdata(cl_wdata3), .cl_rdata(cl_rdata3), .cl_resp(cl_resp3),
        .pmem_read(pmem_read3), .pmem_write(pmem_write3), .pmem_address(pmem_address3),
        .pmem_wdata(pmem_wdata3), .pmem_rdata(pmem_rdata3), .pmem_resp(pmem_resp3)
    );

    // pmem model for the default instance: wait_cycles idle cycles before each beat.
    logic [63:0] rd_beats [8];
    logic [63:0] wlog [8];
    int wait_cycles = 0;
    int m_beat = 0;
    int m_wcnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            pmem_resp = 1'b0;
            m_beat    = 0;
            m_wcnt    = 0;
        end else begin
            pmem_resp = 1'b0;
            if (pmem_read || pmem_write) begin
                if (m_wcnt >= wait_cycles) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = rd_beats[m_beat];
                    if (pmem_write) wlog[m_beat] = pmem_wdata;
                    m_beat = (m_beat + 1) % 8;
                    m_wcnt = 0;
                end else begin
                    m_wcnt++;
                end
            end else begin
                m_beat = 0;
                m_wcnt = 0;
            end
        end
    end

    // Zero-wait pmem model for the wide instance; beat k returns 0x3000...0k.
    int m3_beat = 0;
    always @(negedge clk) begin
        if (!rst || !(pmem_read3 || pmem_write3)) begin
            pmem_resp3 = 1'b0;
            m3_beat    = 0;
        end else begin
            pmem_resp3  = 1'b1;
            pmem_rdata3 = 64'h3000_0000_0000_0000 | 64'(m3_beat);
            m3_beat     = (m3_beat + 1) % 8;
        end
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One-hot decode: index of the set bit, 99 when not exactly one bit.
    function automatic int oh_idx(input logic [7:0] v);
        int r = 99;
        for (int i = 0; i < 8; i++)
            if (v == (8'd1 << i)) r = i;
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        cl_read = '0; cl_write = '0; cl_read3 = '0; cl_write3 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Issue one request on the default instance and follow it to completion.
    task automatic run_req(input int port, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] exp_addr,
                           input logic [255:0] line,
                           output int lat, output int got_port, output logic [255:0] got_rdata,
                           output int addr_bad, output int rd_hi, output int both_hi,
                           output logic [1:0] resp_after);
        lat = 1; got_port = -1; got_rdata = '0; addr_bad = 0; rd_hi = 0; both_hi = 0;
        cl_address[port*32 +: 32] = addr;
        cl_wdata[port*256 +: 256] = line;
        cl_read[port]  = rd;
        cl_write[port] = wr;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            lat++;
            if (pmem_read) rd_hi++;
            if (pmem_read && pmem_write) both_hi++;
            if ((pmem_read || pmem_write) && pmem_address !== exp_addr) addr_bad++;
            if (cl_resp != 2'b00) begin
                got_port  = oh_idx({6'd0, cl_resp});
                got_rdata = cl_rdata;
                break;
            end
        end
        cl_read[port]  = 1'b0;
        cl_write[port] = 1'b0;
        @(posedge clk); #1;
        resp_after = cl_resp;
    endtask

    initial begin
        int lat, gp, abad, rdh, both;
        logic [255:0] rdat;
        logic [1:0] ra;
        int order [6];
        int left [2];
        int done;
        int port3 [2];
        int lat3, lat3_first, taken;
        logic [31:0] addr3 [2];
        logic [511:0] rd3 [2];
        logic [511:0] exp3;
        int exp_order [6];

        rd_beats[0] = 64'h1111_1111_1111_1111;
        rd_beats[1] = 64'h2222_2222_2222_2222;
        rd_beats[2] = 64'h3333_3333_3333_3333;
        rd_beats[3] = 64'h4444_4444_4444_4444;
        for (int k = 4; k < 8; k++) rd_beats[k] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_pmem_read",  pmem_read,    0);
        check("rst_pmem_write", pmem_write,   0);
        check("rst_address",    pmem_address, 0);
        check("rst_wdata",      pmem_wdata,   0);
        check("rst_cl_resp",    cl_resp,      0);
        check("rst_cl_rdata",   cl_rdata,     0);
        check("rst_cl_resp3",   cl_resp3,     0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Single zero-wait read, port 0
        wait_cycles = 0;
        run_req(0, 1'b1, 1'b0, 32'h0000_1234, 32'h0000_1220, '0, lat, gp, rdat, abad, rdh, both, ra);
        check("rd_port",     gp,   0);
        check("rd_latency",  lat,  6);
        check("rd_rdata",    rdat, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        check("rd_addr_hold", abad, 0);
        check("rd_resp_one_cycle", ra, 0);

        // Single write, port 1, two wait cycles per beat
        wait_cycles = 2;
        run_req(1, 1'b0, 1'b1, 32'h0000_5678, 32'h0000_5660,
                {64'hAAAA_BBBB_CCCC_DDD3, 64'hAAAA_BBBB_CCCC_DDD2,
                 64'hAAAA_BBBB_CCCC_DDD1, 64'hAAAA_BBBB_CCCC_DDD0},
                lat, gp, rdat, abad, rdh, both, ra);
        check("wr_port",      gp,   1);
        check("wr_latency",   lat,  14);
        check("wr_rdata_zero", rdat, 0);
        check("wr_addr_hold", abad, 0);
        check("wr_no_read",   rdh,  0);
        check("wr_beat0", wlog[0], 64'hAAAA_BBBB_CCCC_DDD0);
        check("wr_beat1", wlog[1], 64'hAAAA_BBBB_CCCC_DDD1);
        check("wr_beat2", wlog[2], 64'hAAAA_BBBB_CCCC_DDD2);
        check("wr_beat3", wlog[3], 64'hAAAA_BBBB_CCCC_DDD3);

        // Read and write together on port 0: write wins
        wait_cycles = 0;
        run_req(0, 1'b1, 1'b1, 32'h9000_003F, 32'h9000_0020,
                {64'h4, 64'h3, 64'h2, 64'h1}, lat, gp, rdat, abad, rdh, both, ra);
        check("rw_port",      gp,  0);
        check("rw_no_read",   rdh, 0);
        check("rw_not_both",  both, 0);
        check("rw_beat0",     wlog[0], 64'h1);
        check("rw_beat3",     wlog[3], 64'h4);

        // Both ports held for three reads each, starting from rr_ptr = 0
`ifdef PMEM_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 1, 1, 1};
`else
        exp_order = '{0, 1, 0, 1, 0, 1};
`endif
        do_reset();
        @(posedge clk); #1;
        left[0] = 3; left[1] = 3; done = 0;
        cl_address = {32'h0000_0200, 32'h0000_0100};
        cl_read = 2'b11;
        for (int c = 0; c < 400 && done < 6; c++) begin
            @(posedge clk); #1;
            if (cl_resp != 2'b00) begin
                order[done] = oh_idx({6'd0, cl_resp});
                if (order[done] < 2) begin
                    left[order[done]]--;
                    if (left[order[done]] == 0) cl_read[order[done]] = 1'b0;
                end
                done++;
            end
        end
        cl_read = 2'b00;
        check("arb_count", done, 6);
        for (int k = 0; k < 6; k++)
            check($sformatf("arb_grant%0d", k), (k < done) ? order[k] : -1, exp_order[k]);
        @(posedge clk); #1;

        // Reset in the middle of a read burst (beat 2 in flight)
        cl_address[31:0] = 32'h0000_0040;
        cl_read[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cl_read = 2'b00;
        @(posedge clk); #1;
        check("mid_rst_pmem_read", pmem_read,    0);
        check("mid_rst_cl_resp",   cl_resp,      0);
        check("mid_rst_rdata",     cl_rdata,     0);
        check("mid_rst_address",   pmem_address, 0);
        rst = 1'b1;
        done = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (cl_resp != 2'b00 || pmem_read) done++;
        end
        check("mid_rst_quiet", done, 0);
        run_req(0, 1'b1, 1'b0, 32'h0000_0080, 32'h0000_0080, '0, lat, gp, rdat, abad, rdh, both, ra);
        check("post_rst_port",    gp,  0);
        check("post_rst_latency", lat, 6);
        check("post_rst_rdata",   rdat, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

        // Wide build: ports 2 and 0 request together
        for (int k = 0; k < 8; k++) exp3[k*64 +: 64] = 64'h3000_0000_0000_0000 | 64'(k);
        cl_address3 = {32'h0000_2345, 32'h0000_0000, 32'h0000_0100};
        cl_read3 = 3'b101;
        lat3 = 1; lat3_first = 0; taken = 0; done = 0;
        port3[0] = -1; port3[1] = -1;
        addr3[0] = '0; addr3[1] = '0;
        rd3[0] = '0; rd3[1] = '0;
        for (int c = 0; c < 200 && done < 2; c++) begin
            @(posedge clk); #1;
            lat3++;
            if (pmem_read3 && taken == 0) begin
                addr3[done] = pmem_address3;
                taken = 1;
            end
            if (cl_resp3 != 3'b000) begin
                port3[done] = oh_idx({5'd0, cl_resp3});
                rd3[done]   = cl_rdata3;
                if (done == 0) lat3_first = lat3;
                cl_read3 = cl_read3 & ~cl_resp3;
                taken = 0;
                done++;
            end
        end
        cl_read3 = 3'b000;
        check("w3_first_port",  port3[0], 0);
        check("w3_second_port", port3[1], 2);
        check("w3_latency",     lat3_first, 10);
        check("w3_addr0",       addr3[0], 32'h0000_0100);
        check("w3_addr2",       addr3[1], 32'h0000_2340);
        check("w3_rdata0",      rd3[0], exp3);
        check("w3_rdata2",      rd3[1], exp3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
